bsg_manycore_hetero_socket_mux: RTL and testbench

BSG_MANYCORE_HETERO_SOCKET_MUX -- requirements
Module: bsg_manycore_hetero_socket_mux

---
 rtl/bsg_manycore_hetero_socket_mux.sv | 189 ++++++++++++++++++
 tb/tb_bsg_manycore_hetero_socket_mux.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_hetero_socket_mux.sv
// bsg_manycore_hetero_socket_mux
//
// Steers one inbound request stream to one of num_chan_p accelerator channels.
// The channel is chosen by a select field in the packet. Responses from all
// channels are merged back through a one-entry output register, using a
// round-robin arbiter. Per-channel outstanding counters limit how many
// requests each channel may have in flight. A quiesce FSM
// (RUN/QUIESCE/HALT) stops new requests and reports when all traffic has
// drained.
//
// Ports:
//   clk_i, reset_n_i                     clock, synchronous active-low reset
//   fwd_v_i/fwd_data_i/fwd_ready_o       inbound requests
//   chan_v_o/chan_data_o/chan_ready_i    per-channel requests (data shared)
//   chan_rev_v_i/chan_rev_data_i/
//   chan_rev_yumi_o                      per-channel responses
//   rev_v_o/rev_data_o/rev_ready_i       merged response output
//   quiesce_i, quiesced_o                drain request / drained (HALT)
//   err_o                                sticky error flag. It is set by a bad
//                                        select or by a response that has no
//                                        matching outstanding request.
//   perf_cnt_o                           per-channel 32-bit forwarded-request
//                                        counts. This port exists only when
//                                        BSG_HETERO_SOCKET_MUX_PERF_CNT_EN is
//                                        defined.
module bsg_manycore_hetero_socket_mux #(
    parameter int num_chan_p  = 4,
    parameter int pkt_width_p = 64,
    parameter int sel_lsb_p   = 0,
    parameter int max_out_p   = 4
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              fwd_v_i,
    input  logic [pkt_width_p-1:0]            fwd_data_i,
    output logic                              fwd_ready_o,
    output logic [num_chan_p-1:0]             chan_v_o,
    output logic [pkt_width_p-1:0]            chan_data_o,
    input  logic [num_chan_p-1:0]             chan_ready_i,
    input  logic [num_chan_p-1:0]             chan_rev_v_i,
    input  logic [num_chan_p*pkt_width_p-1:0] chan_rev_data_i,
    output logic [num_chan_p-1:0]             chan_rev_yumi_o,
    output logic                              rev_v_o,
    output logic [pkt_width_p-1:0]            rev_data_o,
    input  logic                              rev_ready_i,
    input  logic                              quiesce_i,
    output logic                              quiesced_o,
    output logic                              err_o
`ifdef BSG_HETERO_SOCKET_MUX_PERF_CNT_EN
    ,
    output logic [num_chan_p*32-1:0]          perf_cnt_o
`endif
);

    localparam int sel_w = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;
    localparam int cnt_w = $clog2(max_out_p + 1);

    typedef enum logic [1:0] {RUN, QUIESCE, HALT} state_t;

    state_t                 state_reg, state_next;
    logic [cnt_w-1:0]       cnt_reg [num_chan_p];
    logic [num_chan_p-1:0]  cnt_zero, cnt_room, cnt_dec;
    logic                   rev_v_reg;
    logic [pkt_width_p-1:0] rev_data_reg;
    logic [sel_w-1:0]       rr_reg, rr_next;
    logic                   err_reg;

    logic [sel_w-1:0]       sel;
    logic                   bad_sel, sel_ok, fwd_fire, load_en, underflow, all_idle;
    logic                   win_any;
    logic [sel_w-1:0]       win;
    logic [pkt_width_p-1:0] win_data;

    // ---------------- forward path ----------------
    assign sel     = fwd_data_i[sel_lsb_p +: sel_w];
    assign bad_sel = (int'(sel) >= num_chan_p);

    // Ready/room of the selected channel. A loop avoids indexing past num_chan_p.
    always_comb begin
        sel_ok = 1'b0;
        for (int i = 0; i < num_chan_p; i++) begin
            if (sel == sel_w'(i)) sel_ok = chan_ready_i[i] & cnt_room[i];
        end
    end

    assign fwd_ready_o = reset_n_i & (state_reg == RUN) & (bad_sel | sel_ok);
    assign fwd_fire    = fwd_v_i & fwd_ready_o;
    assign chan_data_o = fwd_data_i;

    // ---------------- response arbitration ----------------
    // The register can accept a new response when it is empty or is being
    // drained this cycle.
    assign load_en = ~rev_v_reg | rev_ready_i;

    // Round robin: scan from offset num_chan_p-1 down to 0 relative to rr_reg.
    // The last hit (smallest offset) wins.
    always_comb begin
        int idx;
        idx      = 0;
        win_any  = 1'b0;
        win      = rr_reg;
        win_data = '0;
        for (int k = num_chan_p - 1; k >= 0; k--) begin
            idx = (int'(rr_reg) + k) % num_chan_p;
            if (chan_rev_v_i[idx]) begin
                win_any  = 1'b1;
                win      = sel_w'(idx);
                win_data = chan_rev_data_i[idx*pkt_width_p +: pkt_width_p];
            end
        end
        rr_next = (int'(win) == num_chan_p - 1) ? '0 : win + sel_w'(1);
    end

    generate
        for (genvar gi = 0; gi < num_chan_p; gi++) begin : g_chan
            assign chan_v_o[gi]        = fwd_fire & ~bad_sel & (sel == sel_w'(gi));
            assign chan_rev_yumi_o[gi] = reset_n_i & load_en & win_any & (win == sel_w'(gi));
            assign cnt_zero[gi]        = (cnt_reg[gi] == '0);
            assign cnt_room[gi]        = (cnt_reg[gi] < cnt_w'(max_out_p));
            // A response with nothing outstanding is still accepted, but it does not decrement.
            assign cnt_dec[gi]         = chan_rev_yumi_o[gi] & ~cnt_zero[gi];

            always_ff @(posedge clk_i) begin
                if (!reset_n_i)
                    cnt_reg[gi] <= '0;
                else if (chan_v_o[gi] & ~cnt_dec[gi])
                    cnt_reg[gi] <= cnt_reg[gi] + cnt_w'(1);
                else if (~chan_v_o[gi] & cnt_dec[gi])
                    cnt_reg[gi] <= cnt_reg[gi] - cnt_w'(1);
            end
        end
    endgenerate

    assign underflow = |(chan_rev_yumi_o & cnt_zero);
    assign all_idle  = (&cnt_zero) & ~rev_v_reg;

    // ---------------- state ----------------
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_reg    <= RUN;
            rev_v_reg    <= 1'b0;
            rev_data_reg <= '0;
            rr_reg       <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load_en) begin
                rev_v_reg <= win_any;
                if (win_any) begin
                    rev_data_reg <= win_data;
                    rr_reg       <= rr_next;
                end
            end
            err_reg <= err_reg | (fwd_fire & bad_sel) | underflow;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (quiesce_i) state_next = QUIESCE;
            QUIESCE: if (!quiesce_i) state_next = RUN;
                     else if (all_idle) state_next = HALT;
            HALT:    if (!quiesce_i) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    assign rev_v_o    = reset_n_i & rev_v_reg;
    assign rev_data_o = rev_data_reg;
    assign quiesced_o = reset_n_i & (state_reg == HALT);
    assign err_o      = err_reg;

`ifdef BSG_HETERO_SOCKET_MUX_PERF_CNT_EN
    logic [31:0] perf_reg [num_chan_p];
    generate
        for (genvar gi = 0; gi < num_chan_p; gi++) begin : g_perf
            always_ff @(posedge clk_i) begin
                if (!reset_n_i)
                    perf_reg[gi] <= '0;
                else if (chan_v_o[gi])
                    perf_reg[gi] <= perf_reg[gi] + 32'd1;
            end
            assign perf_cnt_o[gi*32 +: 32] = perf_reg[gi];
        end
    endgenerate
`endif

endmodule

// File: tb/tb_bsg_manycore_hetero_socket_mux.sv
// Testbench for bsg_manycore_hetero_socket_mux.
// u_dut is a 4-channel instance that covers the main behaviour.
// u_dut3 is a 3-channel instance that covers bad-select handling.
// Inputs are driven 1 ns after the rising edge. Outputs are sampled on the
// falling edge. Merged responses are checked against an expected-data queue.
module tb_bsg_manycore_hetero_socket_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n, fwd_v, fwd_ready, rev_ready, quiesce, rev_v, quiesced, err;
    logic [63:0]  fwd_data, chan_data, rev_data;
    logic [3:0]   chan_v, chan_ready, yumi, rv;
    logic [63:0]  rdata [4];
    logic [255:0] rev_flat;
    assign rev_flat = {rdata[3], rdata[2], rdata[1], rdata[0]};

    logic         fwd3_v, fwd3_ready, rev3_v, quiesced3, err3;
    logic [63:0]  fwd3_data, chan3_data, rev3_data;
    logic [2:0]   chan3_v, yumi3;
`ifdef BSG_HETERO_SOCKET_MUX_PERF_CNT_EN
    logic [127:0] perf_cnt;
    logic [95:0]  perf_cnt3;
`endif

    bsg_manycore_hetero_socket_mux #(.num_chan_p(4), .pkt_width_p(64), .sel_lsb_p(0), .max_out_p(4)) u_dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .fwd_v_i(fwd_v), .fwd_data_i(fwd_data), .fwd_ready_o(fwd_ready),
        .chan_v_o(chan_v), .chan_data_o(chan_data), .chan_ready_i(chan_ready),
        .chan_rev_v_i(rv), .chan_rev_data_i(rev_flat), .chan_rev_yumi_o(yumi),
        .rev_v_o(rev_v), .rev_data_o(rev_data), .rev_ready_i(rev_ready),
        .quiesce_i(quiesce), .quiesced_o(quiesced), .err_o(err)
`ifdef BSG_HETERO_SOCKET_MUX_PERF_CNT_EN
        , .perf_cnt_o(perf_cnt)
`endif
    );

    bsg_manycore_hetero_socket_mux #(.num_chan_p(3), .pkt_width_p(64), .sel_lsb_p(0), .max_out_p(4)) u_dut3 (
        .clk_i(clk), .reset_n_i(reset_n),
        .fwd_v_i(fwd3_v), .fwd_data_i(fwd3_data), .fwd_ready_o(fwd3_ready),
        .chan_v_o(chan3_v), .chan_data_o(chan3_data), .chan_ready_i(3'b111),
        .chan_rev_v_i(3'b000), .chan_rev_data_i(192'd0), .chan_rev_yumi_o(yumi3),
        .rev_v_o(rev3_v), .rev_data_o(rev3_data), .rev_ready_i(1'b1),
        .quiesce_i(1'b0), .quiesced_o(quiesced3), .err_o(err3)
`ifdef BSG_HETERO_SOCKET_MUX_PERF_CNT_EN
        , .perf_cnt_o(perf_cnt3)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [63:0] pkt(input logic [1:0] s, input logic [31:0] tag);
        return {tag, 30'h0, s};
    endfunction

    // Scoreboard: every accepted merged response must match the next expected entry.
    always @(negedge clk) begin
        if (reset_n && rev_v && rev_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=%h required=none", rev_data);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                $display("rsp data=%h", rev_data);
                chk("sb_rev_data", rev_data, e);
            end
        end
    end

    // Advance to just after the next rising edge. Drop responses that were
    // accepted at that edge, and clear the default request valid.
    task automatic next_cycle();
        logic [3:0] y;
        y = yumi;
        @(posedge clk);
        #1;
        rv    = rv & ~y;
        fwd_v = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic fwd_one(input logic [1:0] s, input logic [31:0] tag, input logic exp_rdy);
        next_cycle();
        fwd_v      = 1'b1;
        fwd_data   = pkt(s, tag);
        chan_ready = 4'hF;
        settle();
        $display("fwd sel=%0d ready=%b chan_v=%b", s, fwd_ready, chan_v);
        chk("fwd_one_ready", {63'd0, fwd_ready}, {63'd0, exp_rdy});
    endtask

    task automatic respond(input int ch, input logic [63:0] d);
        int n;
        next_cycle();
        rv[ch]    = 1'b1;
        rdata[ch] = d;
        exp_q.push_back(d);
        settle();
        n = 0;
        while (!yumi[ch] && n < 10) begin
            next_cycle();
            settle();
            n++;
        end
        chk("respond_yumi", {63'd0, yumi[ch]}, 64'd1);
    endtask

    typedef struct {
        logic       v;
        logic [1:0] sel;
        logic [3:0] rdy;
        logic       exp_ready;
        logic [3:0] exp_chan_v;
    } vec_t;
    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        tbl[0] = '{1'b1, 2'd2, 4'hF, 1'b1, 4'b0100};
        tbl[1] = '{1'b1, 2'd2, 4'hF, 1'b1, 4'b0100};
        tbl[2] = '{1'b1, 2'd2, 4'hF, 1'b1, 4'b0100};
        tbl[3] = '{1'b1, 2'd2, 4'hF, 1'b1, 4'b0100};
        tbl[4] = '{1'b1, 2'd2, 4'hF, 1'b0, 4'b0000};  // cnt[2] at limit
        tbl[5] = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001};
        tbl[6] = '{1'b1, 2'd1, 4'hD, 1'b0, 4'b0000};  // channel 1 not ready
        tbl[7] = '{1'b1, 2'd1, 4'hF, 1'b1, 4'b0010};
        tbl[8] = '{1'b1, 2'd3, 4'hF, 1'b1, 4'b1000};
        tbl[9] = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0000};  // ready without valid

        reset_n = 1'b0; fwd_v = 1'b1; fwd_data = pkt(2'd0, 32'h0); chan_ready = 4'hF;
        rv = 4'b0001; rdata[0] = 64'h0; rdata[1] = 64'h0; rdata[2] = 64'h0; rdata[3] = 64'h0;
        rev_ready = 1'b1; quiesce = 1'b0;
        fwd3_v = 1'b0; fwd3_data = 64'h0;

        // Reset: the outputs are quiet even with traffic presented.
        repeat (3) begin
            next_cycle();
            fwd_v = 1'b1;
            settle();
        end
        chk("rst_fwd_ready", {63'd0, fwd_ready}, 64'd0);
        chk("rst_chan_v", {60'd0, chan_v}, 64'd0);
        chk("rst_yumi", {60'd0, yumi}, 64'd0);
        chk("rst_rev_v", {63'd0, rev_v}, 64'd0);
        chk("rst_quiesced", {63'd0, quiesced}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        next_cycle();
        reset_n = 1'b1;
        rv = 4'b0000;
        settle();
        chk("post_rst_rev_v", {63'd0, rev_v}, 64'd0);

        // Table-driven forward path
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            fwd_v      = tbl[i].v;
            fwd_data   = pkt(tbl[i].sel, 32'h100 + i);
            chan_ready = tbl[i].rdy;
            settle();
            $display("vec %0d sel=%0d ready=%b chan_v=%b", i, tbl[i].sel, fwd_ready, chan_v);
            chk("tbl_fwd_ready", {63'd0, fwd_ready}, {63'd0, tbl[i].exp_ready});
            chk("tbl_chan_v", {60'd0, chan_v}, {60'd0, tbl[i].exp_chan_v});
            if (tbl[i].exp_chan_v != 4'b0000)
                chk("tbl_chan_data", chan_data, pkt(tbl[i].sel, 32'h100 + i));
        end

        // Simultaneous responses from channels 0, 1 and 3: round-robin order, back to back
        next_cycle();
        chan_ready = 4'hF;
        rv = 4'b1011;
        rdata[0] = 64'hA0; rdata[1] = 64'hA1; rdata[3] = 64'hA3;
        exp_q.push_back(64'hA0); exp_q.push_back(64'hA1); exp_q.push_back(64'hA3);
        settle();
        chk("rr_yumi0", {60'd0, yumi}, 64'b0001);
        chk("rr_rev_v0", {63'd0, rev_v}, 64'd0);
        next_cycle(); settle();
        chk("rr_yumi1", {60'd0, yumi}, 64'b0010);
        chk("rr_data0", rev_data, 64'hA0);
        next_cycle(); settle();
        chk("rr_yumi3", {60'd0, yumi}, 64'b1000);
        chk("rr_data1", rev_data, 64'hA1);
        next_cycle(); settle();
        chk("rr_yumi_none", {60'd0, yumi}, 64'd0);
        chk("rr_data3", rev_data, 64'hA3);
        chk("rr_rev_v3", {63'd0, rev_v}, 64'd1);
        next_cycle(); settle();
        chk("rr_rev_v_end", {63'd0, rev_v}, 64'd0);
        chk("rr_err", {63'd0, err}, 64'd0);

        // Output register holds while stalled
        next_cycle();
        rv = 4'b0100; rdata[2] = 64'hB0; rev_ready = 1'b0;
        exp_q.push_back(64'hB0); exp_q.push_back(64'hB1);
        settle();
        chk("hold_load_yumi", {60'd0, yumi}, 64'b0100);
        next_cycle();
        rv[2] = 1'b1; rdata[2] = 64'hB1;
        settle();
        for (int k = 0; k < 5; k++) begin
            next_cycle(); settle();
            chk("hold_rev_v", {63'd0, rev_v}, 64'd1);
            chk("hold_rev_data", rev_data, 64'hB0);
            chk("hold_no_yumi", {60'd0, yumi}, 64'd0);
        end
        next_cycle();
        rev_ready = 1'b1;
        settle();
        chk("hold_release_yumi", {60'd0, yumi}, 64'b0100);
        next_cycle(); settle();
        chk("hold_next_data", rev_data, 64'hB1);
        next_cycle(); settle();
        chk("hold_drained", {63'd0, rev_v}, 64'd0);

        // Response from a channel with nothing outstanding
        next_cycle();
        rv = 4'b0010; rdata[1] = 64'hC0;
        exp_q.push_back(64'hC0);
        settle();
        chk("uf_yumi", {60'd0, yumi}, 64'b0010);
        chk("uf_err_before", {63'd0, err}, 64'd0);
        next_cycle(); settle();
        chk("uf_err", {63'd0, err}, 64'd1);

        // Drain channel 2 (cnt 2 -> 0)
        respond(2, 64'hD0);
        respond(2, 64'hD1);

        // Quiesce with cnt[1]=2. These forwards also show that cnt[1] did not underflow.
        fwd_one(2'd1, 32'h200, 1'b1);
        fwd_one(2'd1, 32'h201, 1'b1);
        next_cycle();
        quiesce = 1'b1;
        settle();
        next_cycle();
        fwd_v = 1'b1; fwd_data = pkt(2'd0, 32'h202);
        settle();
        chk("q_fwd_ready", {63'd0, fwd_ready}, 64'd0);
        chk("q_chan_v", {60'd0, chan_v}, 64'd0);
        chk("q_not_halted", {63'd0, quiesced}, 64'd0);
        respond(1, 64'hE0);
        respond(1, 64'hE1);
        n = 0;
        while (!quiesced && n < 10) begin
            next_cycle(); settle();
            n++;
        end
        chk("q_halted", {63'd0, quiesced}, 64'd1);
        next_cycle();
        quiesce = 1'b0;
        settle();
        chk("q_halt_hold", {63'd0, quiesced}, 64'd1);
        next_cycle(); settle();
        chk("q_run_quiesced", {63'd0, quiesced}, 64'd0);
        chk("q_run_ready", {63'd0, fwd_ready}, 64'd1);

        // Mid-transfer reset with cnt[0]=3 and the output register loaded
        fwd_one(2'd0, 32'h300, 1'b1);
        fwd_one(2'd0, 32'h301, 1'b1);
        fwd_one(2'd0, 32'h302, 1'b1);
        next_cycle();
        rv = 4'b0001; rdata[0] = 64'hF0; rev_ready = 1'b0;
        settle();
        chk("mr_yumi", {60'd0, yumi}, 64'b0001);
        next_cycle();
        reset_n = 1'b0;
        settle();
        chk("mr_rev_v_in_rst", {63'd0, rev_v}, 64'd0);
        next_cycle();
        reset_n = 1'b1; rev_ready = 1'b1;
        settle();
        chk("mr_err", {63'd0, err}, 64'd0);
        chk("mr_rev_v", {63'd0, rev_v}, 64'd0);
        // Idle after reset: reaches HALT two cycles after quiesce_i
        next_cycle();
        quiesce = 1'b1;
        settle();
        chk("q2_cyc0", {63'd0, quiesced}, 64'd0);
        next_cycle(); settle();
        chk("q2_cyc1", {63'd0, quiesced}, 64'd0);
        next_cycle(); settle();
        chk("q2_cyc2", {63'd0, quiesced}, 64'd1);
        next_cycle();
        quiesce = 1'b0;
        settle();

        // Bad select on the 3-channel instance
        next_cycle();
        fwd3_v = 1'b1; fwd3_data = pkt(2'd3, 32'h400);
        settle();
        $display("bad sel ready=%b chan_v=%b", fwd3_ready, chan3_v);
        chk("bad_ready", {63'd0, fwd3_ready}, 64'd1);
        chk("bad_chan_v", {61'd0, chan3_v}, 64'd0);
        chk("bad_err_before", {63'd0, err3}, 64'd0);
        next_cycle();
        fwd3_v = 1'b1; fwd3_data = pkt(2'd2, 32'h401);
        settle();
        chk("bad_err", {63'd0, err3}, 64'd1);
        chk("good_chan_v", {61'd0, chan3_v}, 64'b100);
        next_cycle();
        fwd3_v = 1'b0;
        repeat (3) begin
            next_cycle(); settle();
            chk("bad_err_sticky", {63'd0, err3}, 64'd1);
        end

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
